// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm time editor.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  localparam logic [7:0]  HOUR_MAX  = 8'd23;
  localparam logic [7:0]  MIN_MAX   = 8'd59;
  localparam logic [7:0]  SEC_MAX   = 8'd59;
  localparam logic [23:0] ALARM_OFF = 24'hFFFFFF;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // Display field code for a given editor state.
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      EDIT_H:  return FIELD_HOUR;
      EDIT_M:  return FIELD_MIN;
      EDIT_S:  return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

  // Mode button cycles H -> M -> S -> H.
  function automatic state_t next_field(input state_t s);
    case (s)
      EDIT_H:  return EDIT_M;
      EDIT_M:  return EDIT_S;
      default: return EDIT_H;
    endcase
  endfunction

endpackage

// File: rtl/alarm_setter_wrap_counter_step.sv
// wrap_counter_step: combinational +/-1 of an 8-bit field wrapping at 0 and MAX.
// inc and dec together leave the value unchanged.
module wrap_counter_step #(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic [7:0] value,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  // Step up or down with wrap-around, no carry out.
  always_comb begin
    result = value;
    if (inc && !dec) begin
      result = (value >= MAX) ? '0 : value + 8'd1;
    end else if (dec && !inc) begin
      result = (value == '0) ? MAX : value - 8'd1;
    end
  end

endmodule

// File: rtl/alarm_setter.sv
// alarm_setter: button-driven alarm time editor with arm flag, dismiss pulse
// and inactivity timeout. Optional snooze on btn_up dismiss: ALARM_SNOOZE_EN.
module alarm_setter import alarm_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned RESET_HOUR     = 7,
  parameter int unsigned RESET_MIN      = 0,
  parameter int unsigned SNOOZE_MIN     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_set,
  input  logic        ringing,
  output logic [23:0] alarm_clock,
  output logic        switch,
  output logic        armed,
  output logic        editing,
  output logic [1:0]  field_sel,
  output logic [23:0] edit_time
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RST_H = 8'(RESET_HOUR);
  localparam logic [7:0] RST_M = 8'(RESET_MIN);

  state_t        state, state_n;
  logic [7:0]    c_h, c_m, c_s, c_h_n, c_m_n, c_s_n;
  logic [7:0]    s_h, s_m, s_s, s_h_n, s_m_n, s_s_n;
  logic [7:0]    h_step, m_step, s_step;
  logic [CW-1:0] tcnt, tcnt_n;
  logic          armed_n, switch_n;
  logic          press, step_inc, step_dec;

  assign press    = btn_mode | btn_up | btn_down | btn_set;
  assign step_inc = btn_up & ~btn_down;
  assign step_dec = btn_down & ~btn_up;

  wrap_counter_step #(.MAX(HOUR_MAX)) u_step_h (
    .value(s_h), .inc(step_inc), .dec(step_dec), .result(h_step)
  );
  wrap_counter_step #(.MAX(MIN_MAX)) u_step_m (
    .value(s_m), .inc(step_inc), .dec(step_dec), .result(m_step)
  );
  wrap_counter_step #(.MAX(SEC_MAX)) u_step_s (
    .value(s_s), .inc(step_inc), .dec(step_dec), .result(s_step)
  );

`ifdef ALARM_SNOOZE_EN
  logic [8:0] snz_sum;
  logic       snz_carry;
  logic [7:0] snz_h, snz_m;
  logic       snooze;

  assign snz_sum   = {1'b0, c_m} + 9'(SNOOZE_MIN);
  assign snz_carry = (snz_sum >= 9'd60);
  assign snz_m     = snz_carry ? 8'(snz_sum - 9'd60) : snz_sum[7:0];
  assign snooze    = btn_up & ~btn_set & ~btn_mode & ~btn_down;

  wrap_counter_step #(.MAX(HOUR_MAX)) u_snooze_h (
    .value(c_h), .inc(snz_carry), .dec(1'b0), .result(snz_h)
  );
`endif

  // Next-state logic: dismiss first, then set > mode > up/down, then timeout.
  always_comb begin
    state_n  = state;
    c_h_n    = c_h;
    c_m_n    = c_m;
    c_s_n    = c_s;
    s_h_n    = s_h;
    s_m_n    = s_m;
    s_s_n    = s_s;
    armed_n  = armed;
    switch_n = 1'b0;
    tcnt_n   = (state == IDLE || press) ? '0 : tcnt + CW'(1);

    if (ringing && press) begin
      switch_n = 1'b1;
`ifdef ALARM_SNOOZE_EN
      if (snooze) begin
        c_h_n = snz_h;
        c_m_n = snz_m;
      end
`endif
    end else if (state == IDLE) begin
      if (btn_set) begin
        armed_n = ~armed;
      end else if (btn_mode) begin
        s_h_n   = c_h;
        s_m_n   = c_m;
        s_s_n   = c_s;
        state_n = EDIT_H;
      end
    end else if (btn_set) begin
      c_h_n   = s_h;
      c_m_n   = s_m;
      c_s_n   = s_s;
      armed_n = 1'b1;
      state_n = IDLE;
    end else if (btn_mode) begin
      state_n = next_field(state);
    end else if (step_inc || step_dec) begin
      case (state)
        EDIT_H:  s_h_n = h_step;
        EDIT_M:  s_m_n = m_step;
        EDIT_S:  s_s_n = s_step;
        default: ;
      endcase
    end else if (!press && tcnt == TCNT_LAST) begin
      // Abandon the edit: shadow falls back to the committed time.
      s_h_n   = c_h;
      s_m_n   = c_m;
      s_s_n   = c_s;
      state_n = IDLE;
      tcnt_n  = '0;
    end
  end

  // State and registered outputs; outputs are derived from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      c_h         <= RST_H;
      c_m         <= RST_M;
      c_s         <= '0;
      s_h         <= RST_H;
      s_m         <= RST_M;
      s_s         <= '0;
      tcnt        <= '0;
      armed       <= 1'b0;
      switch      <= 1'b0;
      alarm_clock <= ALARM_OFF;
      editing     <= 1'b0;
      field_sel   <= FIELD_NONE;
      edit_time   <= {RST_H, RST_M, 8'd0};
    end else begin
      state       <= state_n;
      c_h         <= c_h_n;
      c_m         <= c_m_n;
      c_s         <= c_s_n;
      s_h         <= s_h_n;
      s_m         <= s_m_n;
      s_s         <= s_s_n;
      tcnt        <= tcnt_n;
      armed       <= armed_n;
      switch      <= switch_n;
      alarm_clock <= armed_n ? {c_h_n, c_m_n, c_s_n} : ALARM_OFF;
      editing     <= (state_n != IDLE);
      field_sel   <= field_of(state_n);
      edit_time   <= (state_n != IDLE) ? {s_h_n, s_m_n, s_s_n} : {c_h_n, c_m_n, c_s_n};
    end
  end

endmodule

// File: tb/tb_alarm_setter.sv
// Bench for alarm_setter: time-of-day model with per-cycle comparison,
// directed scenarios with literal expectations, then random buttons/ringing.
module tb_alarm_setter;

  localparam int unsigned T   = 16;
  localparam int unsigned SNZ = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_set = 1'b0;
  logic        ringing = 1'b0;
  logic [23:0] alarm_clock, edit_time;
  logic        switch, armed, editing;
  logic [1:0]  field_sel;

  alarm_setter #(
    .TIMEOUT_CYCLES(T),
    .RESET_HOUR(7),
    .RESET_MIN(0),
    .SNOOZE_MIN(SNZ)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
    .ringing(ringing),
    .alarm_clock(alarm_clock), .switch(switch), .armed(armed),
    .editing(editing), .field_sel(field_sel), .edit_time(edit_time)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: committed and shadow times as {hour, minute, second} integers.
  int com[3];
  int sh[3];
  int lim[3] = '{24, 60, 60};
  int field;      // 0 = not editing, 1..3 = field being edited
  int idle;       // consecutive press-free editing cycles
  bit marm;
  bit msw;

  function automatic logic [31:0] pack(input int t[3]);
    return 32'((t[0] << 16) | (t[1] << 8) | t[2]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    com   = '{7, 0, 0};
    sh    = '{7, 0, 0};
    field = 0;
    idle  = 0;
    marm  = 1'b0;
    msw   = 1'b0;
  endtask

  task automatic model_step();
    bit any;
    int t;
    any = btn_mode | btn_up | btn_down | btn_set;
    msw = 1'b0;
    if (ringing && any) begin
      msw  = 1'b1;
      idle = 0;
`ifdef ALARM_SNOOZE_EN
      if (btn_up && !btn_set && !btn_mode && !btn_down) begin
        t = com[0] * 60 + com[1] + SNZ;
        com[0] = (t / 60) % 24;
        com[1] = t % 60;
      end
`endif
    end else if (field == 0) begin
      if (btn_set) marm = !marm;
      else if (btn_mode) begin
        sh    = com;
        field = 1;
        idle  = 0;
      end
    end else begin
      if (any) idle = 0;
      if (btn_set) begin
        com   = sh;
        marm  = 1'b1;
        field = 0;
      end else if (btn_mode) begin
        field = (field == 3) ? 1 : field + 1;
      end else if (btn_up && !btn_down) begin
        sh[field-1] = (sh[field-1] + 1) % lim[field-1];
      end else if (btn_down && !btn_up) begin
        sh[field-1] = (sh[field-1] + lim[field-1] - 1) % lim[field-1];
      end else if (!any) begin
        if (idle == int'(T) - 1) begin
          field = 0;
          idle  = 0;
        end else begin
          idle++;
        end
      end
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    if (!reset) begin
      model_step();
      #1;
      chk("alarm_clock", 32'(alarm_clock), marm ? pack(com) : 32'hFFFFFF);
      chk("switch", 32'(switch), 32'(msw));
      chk("armed", 32'(armed), 32'(marm));
      chk("editing", 32'(editing), 32'(field != 0));
      chk("field_sel", 32'(field_sel), 32'(field));
      chk("edit_time", 32'(edit_time), (field != 0) ? pack(sh) : pack(com));
    end
  end

  // One cycle of inputs; returns after that edge has been checked.
  task automatic drive(input bit m, input bit u, input bit d, input bit s, input bit r);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; btn_set = s; ringing = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_mode = 0; btn_up = 0; btn_down = 0; btn_set = 0; ringing = 0;
    model_reset();
    #1;
    chk("rst_alarm_clock", 32'(alarm_clock), 32'hFFFFFF);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_edit_time", 32'(edit_time), 32'h070000);
    chk("rst_field_sel", 32'(field_sel), 32'd0);
    chk("rst_switch", 32'(switch), 32'd0);
    chk("rst_editing", 32'(editing), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int quiet;
    bit ring;
    model_reset();
    do_reset();

    // mode, up x3, mode, down, set -> 10:59:00 armed
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("commit_alarm", 32'(alarm_clock), 32'h0A3B00);
    chk("commit_armed", 32'(armed), 32'd1);
    chk("commit_editing", 32'(editing), 32'd0);

    // Wrap checks: hour 10 down x11 -> 23, up -> 0; second 0 down -> 59
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) drive(0, 0, 1, 0, 0);
    chk("hour_23", 32'(edit_time[23:16]), 32'd23);
    drive(0, 1, 0, 0, 0);
    chk("hour_wrap_up", 32'(edit_time[23:16]), 32'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("field_sec", 32'(field_sel), 32'd3);
    drive(0, 0, 1, 0, 0);
    chk("sec_wrap_down", 32'(edit_time[7:0]), 32'd59);
    drive(0, 1, 1, 0, 0);
    chk("up_down_same", 32'(edit_time), 32'h003B3B);
    drive(0, 0, 0, 1, 0);

    // Timeout after 16 idle edit cycles, committed untouched
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle_cycles(15);
    chk("to_still_edit", 32'(editing), 32'd1);
    idle_cycles(1);
    chk("to_exit", 32'(editing), 32'd0);
    chk("to_committed", 32'(edit_time), 32'h070000);

    // Press on the terminal cycle keeps the edit alive
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle_cycles(15);
    drive(0, 1, 0, 0, 0);
    chk("to_press_wins", 32'(editing), 32'd1);
    chk("to_press_val", 32'(edit_time), 32'h090000);
    idle_cycles(16);
    chk("to_exit2", 32'(editing), 32'd0);

    // Dismiss: single switch pulses, armed unchanged
    do_reset();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    chk("dis_switch", 32'(switch), 32'd1);
    chk("dis_armed", 32'(armed), 32'd1);
    drive(0, 0, 0, 0, 1);
    chk("dis_pulse_end", 32'(switch), 32'd0);
    drive(1, 0, 0, 0, 1);
    chk("dis_switch2", 32'(switch), 32'd1);
    chk("dis_no_edit", 32'(editing), 32'd0);
    drive(0, 0, 0, 0, 0);
    chk("dis_pulse_end2", 32'(switch), 32'd0);

    // Ringing during an edit: press only dismisses
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("ring_edit_stays", 32'(editing), 32'd1);
    drive(0, 1, 0, 0, 1);
    chk("ring_edit_sw", 32'(switch), 32'd1);
    chk("ring_edit_hour", 32'(edit_time[23:16]), 32'd7);
    drive(0, 0, 0, 1, 0);

`ifdef ALARM_SNOOZE_EN
    // Commit 23:58:30 then snooze -> 00:03:30
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 58; i++) drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("snz_pre", 32'(alarm_clock), 32'h173A1E);
    drive(0, 1, 0, 0, 1);
    chk("snz_switch", 32'(switch), 32'd1);
    chk("snz_alarm", 32'(alarm_clock), 32'h00031E);
    chk("snz_armed", 32'(armed), 32'd1);
    drive(0, 0, 0, 0, 0);
`endif

    // Reset mid-edit restores everything
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    do_reset();

    // Random buttons with quiet stretches and ringing bursts
    quiet = 0;
    ring  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit m, u, d, s;
      m = 0; u = 0; d = 0; s = 0;
      if (quiet > 0) begin
        quiet--;
      end else begin
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(10, 20);
        m = ($urandom_range(0, 7) == 0);
        u = ($urandom_range(0, 4) == 0);
        d = ($urandom_range(0, 4) == 0);
        s = ($urandom_range(0, 11) == 0);
      end
      if (ring) ring = ($urandom_range(0, 7) != 0);
      else      ring = ($urandom_range(0, 39) == 0);
      drive(m, u, d, s, ring);
    end

    idle_cycles(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
